map_diff_scanner: RTL and testbench

Parametrised raster scanner for the tile-map display path. It walks a GRID_W×GRID_H cell grid and priority-encodes the per-cell object flags into an object code. It compares each code against a stored copy of the previous frame and issues a draw request, with a cmd_done handshake, only for cells that changed. After reset or a game-over clear it performs one full-redraw pass. It sits between the game-state logic, which answers object flags for the presented x/y, and the display command engine.

---
 rtl/map_diff_scanner_pkg.sv | 19 +
 rtl/map_diff_scanner_if.sv | 33 +++
 rtl/map_diff_scanner_store.sv | 37 +++
 rtl/map_diff_scanner.sv | 126 ++++++++++++
 tb/tb_map_diff_scanner.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_diff_scanner_pkg.sv
// Shared types and defaults for the tile-map difference scanner.
package map_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } scan_state_e;

    localparam int DEF_GRID_W = 16;
    localparam int DEF_GRID_H = 12;
    localparam int DEF_N_OBJ  = 4;

    function automatic int code_width(input int n_obj);
        return $clog2(n_obj + 1);
    endfunction

endpackage

// File: rtl/map_diff_scanner_if.sv
// Scanner bundle: upstream flags, frame/command handshakes, cell address out.
interface map_diff_scanner_if
    import map_scan_pkg::*;
#(
    parameter int N_OBJ  = DEF_N_OBJ,
    parameter int X_W    = $clog2(DEF_GRID_W),
    parameter int Y_W    = $clog2(DEF_GRID_H),
    parameter int CODE_W = code_width(DEF_N_OBJ)
);

    logic [N_OBJ-1:0]  obj_in;
    logic              frame_start;
    logic              cmd_done;
    logic              clear;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [CODE_W-1:0] obj_code;
    logic              diff;
    logic              busy;
    logic              init_cycle;
    logic              frame_done;

    modport master (
        input  obj_in, frame_start, cmd_done, clear,
        output x, y, obj_code, diff, busy, init_cycle, frame_done
    );

    modport slave (
        output obj_in, frame_start, cmd_done, clear,
        input  x, y, obj_code, diff, busy, init_cycle, frame_done
    );

endinterface

// File: rtl/map_diff_scanner_store.sv
// Previous-frame code map: combinational read and one write at the same cell.
module map_store #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic              we,
    input  logic [CODE_W-1:0] wr_data,
    output logic [CODE_W-1:0] rd_data
);

    localparam int DEPTH = GRID_W * GRID_H;
    localparam int A_W   = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [A_W-1:0]    addr;

    assign addr    = A_W'(int'(y) * GRID_W + int'(x));
    assign rd_data = mem[addr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/map_diff_scanner.sv
// Raster scan of the tile grid, issuing draw requests only for changed cells.
module map_diff_scanner
    import map_scan_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int N_OBJ  = DEF_N_OBJ,
    parameter int X_W    = $clog2(GRID_W),
    parameter int Y_W    = $clog2(GRID_H),
    parameter int CODE_W = code_width(N_OBJ)
) (
    input logic              clk,
    input logic              nrst,
    map_diff_scanner_if.master bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [CODE_W-1:0] code_q;
    logic              init_q;

    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] map_rd;
    logic              st_idle, st_scan, st_wait, st_done;
    logic              x_last, last_cell, need_draw, map_we;
    logic [X_W-1:0]    nx;
    logic [Y_W-1:0]    ny;
    logic [1:0]        nxt_state;

    assign st_idle = (state_q == IDLE);
    assign st_scan = (state_q == SCAN);
    assign st_wait = (state_q == WAIT);
    assign st_done = (state_q == DONE);

    // Highest set flag wins; later loop iterations override lower bits.
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (bus.obj_in[i]) enc_code = CODE_W'(i + 1);
        end
    end

    assign x_last    = (x_q == X_W'(GRID_W - 1));
    assign last_cell = x_last && (y_q == Y_W'(GRID_H - 1));
    assign nx        = x_last ? '0 : x_q + 1'b1;
    assign ny        = last_cell ? '0 : (x_last ? y_q + 1'b1 : y_q);
    assign nxt_state = last_cell ? DONE : SCAN;

    assign need_draw = init_q || (enc_code != map_rd);
    assign map_we    = st_scan && need_draw && !bus.clear;

    map_store #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .CODE_W (CODE_W)
    ) u_store (
        .clk     (clk),
        .nrst    (nrst),
        .x       (x_q),
        .y       (y_q),
        .we      (map_we),
        .wr_data (enc_code),
        .rd_data (map_rd)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            code_q  <= '0;
            init_q  <= 1'b1;
        end else if (bus.clear) begin
            // Map is left stale: the forced redraw pass rewrites every cell.
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            init_q  <= 1'b1;
        end else begin
            unique case (1'b1)
                st_idle: begin
                    if (bus.frame_start) state_q <= SCAN;
                end
                st_scan: begin
                    if (need_draw) begin
                        code_q  <= enc_code;
                        state_q <= WAIT;
                    end else begin
                        state_q <= nxt_state;
                        x_q     <= nx;
                        y_q     <= ny;
                    end
                end
                st_wait: begin
                    if (bus.cmd_done) begin
                        state_q <= nxt_state;
                        x_q     <= nx;
                        y_q     <= ny;
                    end
                end
                st_done: begin
                    init_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.obj_code   = code_q;
    assign bus.diff       = st_wait;
    assign bus.busy       = !st_idle;
    assign bus.init_cycle = init_q;
    assign bus.frame_done = st_done;

endmodule

// File: tb/tb_map_diff_scanner.sv
// Randomised bench for map_diff_scanner against a per-pass expected timeline.
module tb_map_diff_scanner;
    import map_scan_pkg::*;

    localparam int GW  = 16;
    localparam int GH  = 12;
    localparam int NO  = 4;
    localparam int XW  = $clog2(GW);
    localparam int YW  = $clog2(GH);
    localparam int CW  = $clog2(NO + 1);
    localparam int SW  = 5;
    localparam int SH  = 3;
    localparam int SXW = $clog2(SW);
    localparam int SYW = $clog2(SH);

    typedef struct {
        int x; int y; int diff; int code; int busy; int fd; int init;
    } rec_t;

    logic tb_clk = 1'b0;
    logic nrst   = 1'b0;
    always #5 tb_clk = ~tb_clk;

    map_diff_scanner_if #(.N_OBJ(NO), .X_W(XW), .Y_W(YW), .CODE_W(CW)) bus ();
    map_diff_scanner_if #(.N_OBJ(NO), .X_W(SXW), .Y_W(SYW), .CODE_W(CW)) sbus ();

    map_diff_scanner #(.GRID_W(GW), .GRID_H(GH), .N_OBJ(NO)) dut (
        .clk (tb_clk), .nrst (nrst), .bus (bus)
    );
    map_diff_scanner #(.GRID_W(SW), .GRID_H(SH), .N_OBJ(NO)) sdut (
        .clk (tb_clk), .nrst (nrst), .bus (sbus)
    );

    logic [NO-1:0] cur_flags [GH][GW];
    int            ref_map   [GH][GW];
    int            m_init;
    rec_t          exp_q [$];
    rec_t          cr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req, n_diffcyc, busy_cyc, exp_cyc, cap_set, cap_x, cap_y, cap_code;

    assign bus.obj_in  = cur_flags[bus.y][bus.x];
    assign sbus.obj_in = '0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [NO-1:0] f);
        for (int i = NO - 1; i >= 0; i--) begin
            if (f[i]) return i + 1;
        end
        return 0;
    endfunction

    // Single compare process: one expected record per cycle of a pass.
    always @(posedge tb_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cr = exp_q.pop_front();
            check("x", int'(bus.x), cr.x);
            check("y", int'(bus.y), cr.y);
            check("diff", int'(bus.diff), cr.diff);
            check("busy", int'(bus.busy), cr.busy);
            check("frame_done", int'(bus.frame_done), cr.fd);
            check("init_cycle", int'(bus.init_cycle), cr.init);
            if (cr.diff != 0) check("obj_code", int'(bus.obj_code), cr.code);
        end
    end

    task automatic run_pass(input int dmode, input bit noise, output int cyc);
        int dl[$];
        int d, wc, ri, code;
        cyc = 0; wc = 0; ri = 0;
        n_diffcyc = 0; busy_cyc = 0; cap_set = 0;
        exp_cyc = 1;
        for (int yy = 0; yy < GH; yy++) begin
            for (int xx = 0; xx < GW; xx++) begin
                code = enc(cur_flags[yy][xx]);
                exp_q.push_back('{xx, yy, 0, 0, 1, 0, m_init});
                exp_cyc++;
                if (m_init != 0 || code != ref_map[yy][xx]) begin
                    ref_map[yy][xx] = code;
                    d = (dmode > 0) ? dmode : int'($urandom_range(1, 3));
                    dl.push_back(d);
                    exp_cyc += d;
                    repeat (d) exp_q.push_back('{xx, yy, 1, code, 1, 0, m_init});
                end
            end
        end
        exp_q.push_back('{0, 0, 0, 0, 1, 1, m_init});
        exp_q.push_back('{0, 0, 0, 0, 0, 0, 0});
        m_init = 0;
        n_req = dl.size();
        bus.frame_start = 1'b1;
        forever begin
            @(negedge tb_clk);
            cyc++;
            if (bus.busy) busy_cyc++;
            if (bus.diff) begin
                n_diffcyc++;
                if (cap_set == 0) begin
                    cap_x = int'(bus.x); cap_y = int'(bus.y);
                    cap_code = int'(bus.obj_code); cap_set = 1;
                end
                wc++;
                if (ri < dl.size() && wc == dl[ri]) begin
                    bus.cmd_done = 1'b1; ri++; wc = 0;
                end else begin
                    bus.cmd_done = 1'b0;
                end
            end else begin
                bus.cmd_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.frame_start = (noise && bus.busy && !bus.frame_done) ?
                              1'($urandom_range(0, 1)) : 1'b0;
            if (bus.frame_done) break;
            if (cyc > exp_cyc + 20) begin
                check("pass_timeout", cyc, exp_cyc);
                break;
            end
        end
        bus.cmd_done = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge tb_clk);
        check("pass_cycles", cyc, exp_cyc);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    int cyc, k, cnt, ccode;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.frame_start = 0; bus.cmd_done = 0; bus.clear = 0;
        sbus.frame_start = 0; sbus.cmd_done = 0; sbus.clear = 0;
        for (int yy = 0; yy < GH; yy++)
            for (int xx = 0; xx < GW; xx++) begin
                cur_flags[yy][xx] = '0;
                ref_map[yy][xx] = 0;
            end
        m_init = 1;
        check("enc_0101", enc(4'b0101), 3);
        check("enc_0011", enc(4'b0011), 2);
        check("enc_0000", enc(4'b0000), 0);

        repeat (3) @(negedge tb_clk);
        nrst = 1'b1;
        @(negedge tb_clk);
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_diff", int'(bus.diff), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_obj_code", int'(bus.obj_code), 0);
        check("rst_init", int'(bus.init_cycle), 1);

        // First pass after reset is a full redraw with immediate acks.
        run_pass(1, 0, cyc);
        check("redraw_requests", n_req, 192);
        check("redraw_cycles", cyc, 385);
        check("init_after_redraw", int'(bus.init_cycle), 0);

        // Stray cmd_done in IDLE leaves the scanner idle.
        repeat (3) begin
            bus.cmd_done = 1'b1;
            @(negedge tb_clk);
            check("idle_cmd_done_busy", int'(bus.busy), 0);
        end
        bus.cmd_done = 1'b0;

        run_pass(0, 1, cyc);
        check("steady_requests", n_req, 0);
        check("steady_diff_cycles", n_diffcyc, 0);
        check("steady_done_cycle", cyc, 193);
        check("steady_busy_cycles", busy_cyc, 193);

        cur_flags[4][7] = 4'b1000;
        run_pass(5, 0, cyc);
        check("single_requests", n_req, 1);
        check("single_x", cap_x, 7);
        check("single_y", cap_y, 4);
        check("single_code", cap_code, 4);
        check("single_diff_cycles", n_diffcyc, 5);

        cur_flags[5][9] = 4'b0011;
        run_pass(2, 1, cyc);
        check("overlap_requests", n_req, 1);
        check("overlap_x", cap_x, 9);
        check("overlap_y", cap_y, 5);
        check("overlap_code", cap_code, 2);

        for (int p = 0; p < 3; p++) begin
            for (int yy = 0; yy < GH; yy++)
                for (int xx = 0; xx < GW; xx++)
                    if ($urandom_range(0, 9) == 0)
                        cur_flags[yy][xx] = 4'($urandom_range(0, 15));
            run_pass(0, 1, cyc);
        end

        // Clear while waiting at (3,2), coinciding with cmd_done.
        ccode = (ref_map[2][3] == 3) ? 2 : 3;
        cur_flags[2][3] = (ccode == 3) ? 4'b0100 : 4'b0010;
        bus.frame_start = 1'b1;
        k = 0;
        do begin
            @(negedge tb_clk);
            bus.frame_start = 1'b0;
            k++;
        end while (!bus.diff && k < 300);
        check("clear_wait_reached", int'(bus.diff), 1);
        check("clear_wait_x", int'(bus.x), 3);
        check("clear_wait_y", int'(bus.y), 2);
        check("clear_wait_code", int'(bus.obj_code), ccode);
        ref_map[2][3] = ccode;
        bus.clear = 1'b1;
        bus.cmd_done = 1'b1;
        @(negedge tb_clk);
        bus.clear = 1'b0;
        bus.cmd_done = 1'b0;
        check("clear_diff", int'(bus.diff), 0);
        check("clear_x", int'(bus.x), 0);
        check("clear_y", int'(bus.y), 0);
        check("clear_init", int'(bus.init_cycle), 1);
        check("clear_busy", int'(bus.busy), 0);
        check("clear_frame_done", int'(bus.frame_done), 0);
        m_init = 1;

        // Clear outranks frame_start in the same cycle.
        bus.clear = 1'b1;
        bus.frame_start = 1'b1;
        @(negedge tb_clk);
        bus.clear = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge tb_clk);
        check("clear_vs_start_busy", int'(bus.busy), 0);

        run_pass(0, 1, cyc);
        check("post_clear_requests", n_req, 192);
        check("post_clear_init", int'(bus.init_cycle), 0);
        run_pass(0, 1, cyc);
        check("post_clear_steady", cyc, 193);

        // Non-power-of-2 grid: redraw, then a no-change pass.
        sbus.frame_start = 1'b1;
        k = 0; cnt = 0;
        forever begin
            @(negedge tb_clk);
            k++;
            sbus.frame_start = 1'b0;
            sbus.cmd_done = sbus.diff;
            if (sbus.diff) cnt++;
            if (sbus.frame_done || k > 200) break;
        end
        sbus.cmd_done = 1'b0;
        check("small_redraw_requests", cnt, 15);
        check("small_redraw_cycles", k, 31);
        @(negedge tb_clk);
        check("small_init_after", int'(sbus.init_cycle), 0);

        sbus.frame_start = 1'b1;
        k = 0;
        forever begin
            @(negedge tb_clk);
            k++;
            sbus.frame_start = 1'b0;
            if (k <= 15) begin
                check("small_x", int'(sbus.x), (k - 1) % SW);
                check("small_y", int'(sbus.y), (k - 1) / SW);
            end
            check("small_diff", int'(sbus.diff), 0);
            if (sbus.frame_done || k > 100) break;
        end
        check("small_done_cycle", k, 16);
        @(negedge tb_clk);
        check("small_idle", int'(sbus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
